// File: rtl/cwru_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cwru_pkg : shared constants, codewords and FSM state for the CWRU link
// Rev 1.0
// ----------------------------------------------------------------------------
package cwru_pkg;

  localparam int CWRU_CLKS_PER_BIT = 12500;
  localparam int CWRU_FRAME_BITS   = 8;

  localparam logic [7:0] CODE_KEY0 = 8'h80;
  localparam logic [7:0] CODE_KEY1 = 8'hA0;
  localparam logic [7:0] CODE_KEY2 = 8'hA8;
  localparam logic [7:0] CODE_KEY3 = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  // Active-low, bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {valid, key[1:0]} for a received frame
  function automatic logic [2:0] decode_code(input logic [7:0] i_word);
    case (i_word)
      CODE_KEY0: decode_code = 3'b100;
      CODE_KEY1: decode_code = 3'b101;
      CODE_KEY2: decode_code = 3'b110;
      CODE_KEY3: decode_code = 3'b111;
      default:   decode_code = 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cwru_hex7seg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cwru_hex7seg : combinational digit to active-low seven-segment decoder
// Rev 1.0
// ----------------------------------------------------------------------------
module cwru_hex7seg
  import cwru_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cwru_transceiver_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cwru_transceiver_rx : OOK key-press frame receiver driving HEX0
// Rev 1.0
// ----------------------------------------------------------------------------
module cwru_transceiver_rx
  import cwru_pkg::*;
#(
  parameter int CLKS_PER_BIT = CWRU_CLKS_PER_BIT,
  parameter int FRAME_BITS   = CWRU_FRAME_BITS,
  parameter int RX_PIN       = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [35:0] GPIO_1,
  output logic [6:0]  HEX0
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] c_idx_first = IW'(FRAME_BITS - 2);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  rx_state_t             r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic [6:0]            r_hex;

  logic                  w_rise;
  logic [2:0]            w_code;
  logic [6:0]            w_seg;
  logic                  w_unused_gpio;

  assign w_rise        = r_sync2 & ~r_prev;
  assign w_code        = decode_code(r_shift);
  assign w_unused_gpio = ^GPIO_1;
  assign HEX0          = r_hex;

  cwru_hex7seg u_hex7seg (
    .i_digit ({2'b00, w_code[1:0]}),
    .o_seg   (w_seg)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_hex   <= SEG_BLANK;
    end else begin
      r_sync1 <= GPIO_1[RX_PIN];
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == c_half_last) begin
            r_cnt <= '0;
            // A start bit that has fallen by mid-bit is treated as a glitch
            if (r_sync2) begin
              r_shift[FRAME_BITS-1] <= 1'b1;
              r_idx                 <= c_idx_first;
              r_state               <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == c_bit_last) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_sync2;
            if (r_idx == '0) r_state <= ST_DONE;
            else             r_idx   <= r_idx - 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (w_code[2]) r_hex <= w_seg;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cwru_transceiver_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cwru_transceiver_rx : scoreboard bench for the CWRU receiver (short bit time)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cwru_transceiver_rx;

  localparam int CPB   = 16;
  localparam int FBITS = 8;
  localparam int PIN   = 15;
  // pin edge to HEX0 update: 2 + CPB/2 + 7*CPB + 2
  localparam int LAT   = 2 + CPB / 2 + 7 * CPB + 2;

  localparam logic [6:0] E_0     = 7'b1000000;
  localparam logic [6:0] E_1     = 7'b1111001;
  localparam logic [6:0] E_2     = 7'b0100100;
  localparam logic [6:0] E_3     = 7'b0110000;
  localparam logic [6:0] E_BLANK = 7'b1111111;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [35:0] GPIO_1 = '0;
  logic [6:0]  HEX0;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [6:0] exp_hex = E_BLANK;
  logic [6:0] exp_q[$];

  cwru_transceiver_rx #(
    .CLKS_PER_BIT (CPB),
    .FRAME_BITS   (FBITS),
    .RX_PIN       (PIN)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .GPIO_1 (GPIO_1),
    .HEX0   (HEX0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: HEX0 got %b expected %b", tag, got, exp);
    end
  endtask

  // Noise on every unused header pin; only PIN carries data
  task automatic drive(input logic v);
    logic [35:0] n;
    n = {4'($urandom), 32'($urandom)};
    n[PIN] = v;
    GPIO_1 = n;
  endtask

  task automatic idle_low(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      drive(1'b0);
    end
  endtask

  function automatic logic [6:0] model(input logic [7:0] w, input logic [6:0] cur);
    case (w)
      8'h80:   model = E_0;
      8'hA0:   model = E_1;
      8'hA8:   model = E_2;
      8'hAA:   model = E_3;
      default: model = cur;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] w);
    logic [6:0] prev_exp;
    logic [6:0] popped;
    prev_exp = exp_hex;
    exp_hex  = model(w, exp_hex);
    exp_q.push_back(exp_hex);
    for (int c = 0; c < FBITS * CPB; c++) begin
      @(negedge CLK);
      drive(w[7 - c / CPB]);
      @(posedge CLK);
      #1;
      if (c == LAT - 4) chk($sformatf("hold_%h", w), HEX0, prev_exp);
      if (c == LAT + 1) begin
        popped = exp_q.pop_front();
        chk($sformatf("frame_%h", w), HEX0, popped);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0);
    repeat (4) @(posedge CLK);
    #1 chk("in_reset", HEX0, E_BLANK);
    @(negedge CLK) RST = 1'b0;
    idle_low(CPB);
    @(posedge CLK); #1 chk("idle_low", HEX0, E_BLANK);

    // Line already high when reset releases
    @(negedge CLK) begin RST = 1'b1; drive(1'b1); end
    @(negedge CLK) begin RST = 1'b0; drive(1'b1); end
    repeat (3 * CPB) begin @(negedge CLK); drive(1'b1); end
    idle_low(10 * CPB);
    @(posedge CLK); #1 chk("high_at_reset", HEX0, E_BLANK);

    send_frame(8'h80); idle_low(2 * CPB);
    send_frame(8'hA0); idle_low(2 * CPB);
    send_frame(8'hA8); idle_low(2 * CPB);
    send_frame(8'hAA); idle_low(2 * CPB);
    send_frame(8'hC0); idle_low(2 * CPB);
    send_frame(8'h81); idle_low(2 * CPB);

    // Short glitch, shorter than half a bit
    repeat (2) begin @(negedge CLK); drive(1'b1); end
    idle_low(2 * CPB);
    @(posedge CLK); #1 chk("glitch", HEX0, exp_hex);

    // Reset mid-frame of 10101010, then line held low
    for (int c = 0; c < 3 * CPB; c++) begin
      @(negedge CLK);
      drive(c / CPB == 0 || c / CPB == 2);
    end
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1 chk("reset_mid", HEX0, E_BLANK);
    @(negedge CLK) begin RST = 1'b0; drive(1'b0); end
    exp_hex = E_BLANK;
    idle_low(10 * CPB);
    @(posedge CLK); #1 chk("after_abort", HEX0, E_BLANK);

    send_frame(8'hA8); idle_low(2 * CPB);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
